// File: rtl/id_exe_hazard_ctrl.sv
// Issue/hazard controller for the ID/EXE register: tracks pending vector and scalar
// writes, stalls on RAW/WAW, holds the front end during multi-cycle ops, squashes on branches.
module id_exe_hazard_ctrl #(
    parameter int NREG      = 8,
    parameter int AW        = 3,
    parameter int MC_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic            id_rs1_vec,
    input  logic            id_rs1_use,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs2_vec,
    input  logic            id_rs2_use,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_wrv,
    input  logic            id_wrs,
    input  logic            id_multicycle,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            wb_wrv,
    input  logic            wb_wrs,
    input  logic            br_taken,
    output logic            issue,
    output logic            bubble_ex,
    output logic            stall_front,
    output logic            flush_id,
    output logic            kill_ex,
    output logic [NREG-1:0] busy_vec,
    output logic [NREG-1:0] busy_scl,
    output logic            multi_busy
);

    localparam int CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

    typedef enum logic {ST_RUN, ST_MULTI} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [NREG-1:0] busy_vec_reg, busy_vec_next;
    logic [NREG-1:0] busy_scl_reg, busy_scl_next;
    logic            exe_valid_reg;
    logic [AW-1:0]   exe_rd_reg;
    logic            exe_wrv_reg;
    logic            exe_wrs_reg;

    logic [NREG-1:0] wb_clr_vec, wb_clr_scl;
    logic [NREG-1:0] kill_clr_vec, kill_clr_scl;
    logic [NREG-1:0] set_vec, set_scl;
    logic [NREG-1:0] pend_vec, pend_scl;
    logic            raw, waw, hazard;

    // Per-register decode of the WB clear, the branch-kill clear and the issue set.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bits
            assign wb_clr_vec[gi]   = wb_valid & wb_wrv & (wb_rd == AW'(gi));
            assign wb_clr_scl[gi]   = wb_valid & wb_wrs & (wb_rd == AW'(gi));
            assign kill_clr_vec[gi] = kill_ex & exe_valid_reg & exe_wrv_reg & (exe_rd_reg == AW'(gi));
            assign kill_clr_scl[gi] = kill_ex & exe_valid_reg & exe_wrs_reg & (exe_rd_reg == AW'(gi));
            assign set_vec[gi]      = issue & id_wrv & (id_rd == AW'(gi));
            assign set_scl[gi]      = issue & id_wrs & (id_rd == AW'(gi));
        end
    endgenerate

    // A register written back this cycle is readable now: the file writes before it reads.
    assign pend_vec = busy_vec_reg & ~wb_clr_vec;
    assign pend_scl = busy_scl_reg & ~wb_clr_scl;

    assign raw = (id_rs1_use & (id_rs1_vec ? pend_vec[id_rs1] : pend_scl[id_rs1]))
               | (id_rs2_use & (id_rs2_vec ? pend_vec[id_rs2] : pend_scl[id_rs2]));
    assign waw = (id_wrv & pend_vec[id_rd]) | (id_wrs & pend_scl[id_rd]);
    assign hazard = id_valid & (raw | waw);

    always_comb begin
        issue       = 1'b0;
        bubble_ex   = 1'b1;
        stall_front = 1'b0;
        flush_id    = 1'b0;
        kill_ex     = 1'b0;
        if (!rst_n) begin
            issue = 1'b0;
        end else if (br_taken) begin
            flush_id = 1'b1;
            kill_ex  = 1'b1;
        end else if (state_reg == ST_MULTI) begin
            stall_front = 1'b1;
        end else begin
            issue       = id_valid & ~hazard;
            stall_front = hazard;
            bubble_ex   = ~(id_valid & ~hazard);
        end
    end

    // Set after clear so a same-cycle WB and issue of one register leaves it busy.
    assign busy_vec_next = (busy_vec_reg & ~wb_clr_vec & ~kill_clr_vec) | set_vec;
    assign busy_scl_next = (busy_scl_reg & ~wb_clr_scl & ~kill_clr_scl) | set_scl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec_reg <= '0;
            busy_scl_reg <= '0;
        end else begin
            busy_vec_reg <= busy_vec_next;
            busy_scl_reg <= busy_scl_next;
        end
    end

    // EXE record: held while a multi-cycle op occupies EXE so a branch can still kill it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_reg <= 1'b0;
            exe_rd_reg    <= '0;
            exe_wrv_reg   <= 1'b0;
            exe_wrs_reg   <= 1'b0;
        end else if (kill_ex) begin
            exe_valid_reg <= 1'b0;
        end else if (state_reg == ST_MULTI) begin
            exe_valid_reg <= exe_valid_reg;
        end else if (issue) begin
            exe_valid_reg <= 1'b1;
            exe_rd_reg    <= id_rd;
            exe_wrv_reg   <= id_wrv;
            exe_wrs_reg   <= id_wrs;
        end else begin
            exe_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (issue && id_multicycle) begin
                        state_reg <= ST_MULTI;
                        cnt_reg   <= CW'(MC_CYCLES - 1);
                    end
                end
                ST_MULTI: begin
                    if (br_taken || cnt_reg == CW'(1)) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign busy_vec   = busy_vec_reg;
    assign busy_scl   = busy_scl_reg;
    assign multi_busy = (state_reg == ST_MULTI);

endmodule

// File: tb/tb_id_exe_hazard_ctrl.sv
// Bench for id_exe_hazard_ctrl: directed scenarios plus randomized cycles checked
// against a register-level behavioural model of the scoreboard and multi-cycle stall.
module tb_id_exe_hazard_ctrl;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int MC   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_rs1_vec, id_rs1_use, id_rs2_vec, id_rs2_use;
    logic id_wrv, id_wrs, id_multicycle, wb_valid, wb_wrv, wb_wrs, br_taken;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic issue, bubble_ex, stall_front, flush_id, kill_ex, multi_busy;
    logic [NREG-1:0] busy_vec, busy_scl;
    logic [5:0] ctl;

    int checks = 0;
    int errors = 0;

    // Model state: one bit per register and file, plus remaining front-end stall cycles.
    bit m_vec [NREG];
    bit m_scl [NREG];

    id_exe_hazard_ctrl #(.NREG(NREG), .AW(AW), .MC_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_vec(id_rs1_vec), .id_rs1_use(id_rs1_use),
        .id_rs2(id_rs2), .id_rs2_vec(id_rs2_vec), .id_rs2_use(id_rs2_use),
        .id_rd(id_rd), .id_wrv(id_wrv), .id_wrs(id_wrs), .id_multicycle(id_multicycle),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wrv(wb_wrv), .wb_wrs(wb_wrs),
        .br_taken(br_taken), .issue(issue), .bubble_ex(bubble_ex),
        .stall_front(stall_front), .flush_id(flush_id), .kill_ex(kill_ex),
        .busy_vec(busy_vec), .busy_scl(busy_scl), .multi_busy(multi_busy)
    );

    always #5 clk = ~clk;

    // {issue, bubble_ex, stall_front, flush_id, kill_ex, multi_busy}
    assign ctl = {issue, bubble_ex, stall_front, flush_id, kill_ex, multi_busy};

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = '0; id_rs1_vec = 0; id_rs1_use = 0;
        id_rs2 = '0; id_rs2_vec = 0; id_rs2_use = 0; id_rd = '0;
        id_wrv = 0; id_wrs = 0; id_multicycle = 0;
        wb_valid = 0; wb_rd = '0; wb_wrv = 0; wb_wrs = 0; br_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
    endtask

    task automatic drive_write(input int rd, input bit v, input bit s, input bit mc);
        clear_inputs();
        id_valid = 1; id_rd = AW'(rd); id_wrv = v; id_wrs = s; id_multicycle = mc;
    endtask

    function automatic bit pend(input int r, input bit v);
        bit b;
        b = v ? m_vec[r] : m_scl[r];
        if (wb_valid && wb_rd == AW'(r) && (v ? wb_wrv : wb_wrs)) b = 0;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 0; clear_inputs();
        id_valid = 1; id_rd = 3; id_wrv = 1; br_taken = 1;
        #2;
        $display("test_reset: in reset ctl=%b", ctl);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL reset_ctl: ctl=%b expected=%b", ctl, 6'b010000); end
        @(posedge clk); #1;
        checks++; if ({busy_vec, busy_scl} !== 16'h0000) begin errors++; $display("FAIL reset_busy: busy=%h expected=0000", {busy_vec, busy_scl}); end
        clear_inputs(); rst_n = 1; #1;
        $display("test_reset: released ctl=%b busy=%h", ctl, {busy_vec, busy_scl});
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL reset_idle: ctl=%b expected=%b", ctl, 6'b010000); end
    endtask

    task automatic test_raw_wb_bypass();
        do_reset();
        drive_write(3, 1, 0, 0); #1;
        $display("test_raw: issue wrv rd=3 ctl=%b", ctl);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL raw_first_issue: ctl=%b expected=%b", ctl, 6'b100000); end
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 3; id_rs1_vec = 1; id_rs1_use = 1; #1;
        $display("test_raw: read v3 ctl=%b busy_vec=%h", ctl, busy_vec);
        checks++; if (busy_vec !== 8'h08) begin errors++; $display("FAIL raw_busy_set: busy_vec=%h expected=08", busy_vec); end
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL raw_stall1: ctl=%b expected=%b", ctl, 6'b011000); end
        tick(); #1;
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL raw_stall2: ctl=%b expected=%b", ctl, 6'b011000); end
        tick();
        wb_valid = 1; wb_rd = 3; wb_wrv = 1; #1;
        $display("test_raw: wb v3 ctl=%b", ctl);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL raw_wb_bypass: ctl=%b expected=%b", ctl, 6'b100000); end
        tick(); clear_inputs(); #1;
        checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL raw_busy_clr: busy_vec=%h expected=00", busy_vec); end
    endtask

    task automatic test_scalar_vs_vector();
        do_reset();
        drive_write(5, 0, 1, 0); #1;
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 5; id_rs1_vec = 1; id_rs1_use = 1; #1;
        $display("test_sv: read v5 with s5 pending ctl=%b busy_scl=%h", ctl, busy_scl);
        checks++; if (busy_scl !== 8'h20) begin errors++; $display("FAIL sv_busy: busy_scl=%h expected=20", busy_scl); end
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL sv_no_stall: ctl=%b expected=%b", ctl, 6'b100000); end
        id_rs1_use = 0; id_rd = 5; id_wrs = 1; #1;
        $display("test_sv: write s5 ctl=%b", ctl);
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL sv_waw: ctl=%b expected=%b", ctl, 6'b011000); end
        id_wrs = 0; id_rs2 = 5; id_rs2_vec = 0; id_rs2_use = 1; #1;
        $display("test_sv: read s5 ctl=%b", ctl);
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL sv_raw_scl: ctl=%b expected=%b", ctl, 6'b011000); end
    endtask

    task automatic test_multicycle();
        int n;
        do_reset();
        drive_write(1, 1, 0, 1); #1;
        $display("test_mc: issue mc ctl=%b", ctl);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL mc_issue: ctl=%b expected=%b", ctl, 6'b100000); end
        tick();
        drive_write(4, 0, 1, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall_front) break;
            $display("test_mc: stall cycle %0d ctl=%b", n, ctl);
            checks++; if (ctl !== 6'b011001) begin errors++; $display("FAIL mc_multi_ctl: ctl=%b expected=%b", ctl, 6'b011001); end
            n++;
            tick();
        end
        checks++; if (n != MC - 1) begin errors++; $display("FAIL mc_stall_len: cycles=%0d expected=%0d", n, MC - 1); end
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL mc_next_issue: ctl=%b expected=%b", ctl, 6'b100000); end
        tick(); clear_inputs(); #1;
        checks++; if ({busy_vec, busy_scl} !== 16'h0210) begin errors++; $display("FAIL mc_busy: busy=%h expected=0210", {busy_vec, busy_scl}); end
    endtask

    task automatic test_branch_kill();
        do_reset();
        drive_write(2, 1, 0, 0); #1;
        tick();
        drive_write(6, 1, 0, 0); br_taken = 1; #1;
        $display("test_br: branch ctl=%b busy_vec=%h", ctl, busy_vec);
        checks++; if (busy_vec !== 8'h04) begin errors++; $display("FAIL br_busy_before: busy_vec=%h expected=04", busy_vec); end
        checks++; if (ctl !== 6'b010110) begin errors++; $display("FAIL br_ctl: ctl=%b expected=%b", ctl, 6'b010110); end
        tick(); clear_inputs(); #1;
        checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL br_busy_after: busy_vec=%h expected=00", busy_vec); end
    endtask

    task automatic test_set_wins();
        do_reset();
        drive_write(7, 0, 1, 0); #1;
        tick();
        drive_write(7, 0, 1, 0); wb_valid = 1; wb_rd = 7; wb_wrs = 1; #1;
        $display("test_setwins: wb+issue s7 ctl=%b", ctl);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL setwins_issue: ctl=%b expected=%b", ctl, 6'b100000); end
        tick(); clear_inputs(); #1;
        checks++; if (busy_scl !== 8'h80) begin errors++; $display("FAIL setwins_busy: busy_scl=%h expected=80", busy_scl); end
    endtask

    task automatic test_mc_branch_and_reset();
        do_reset();
        drive_write(0, 1, 0, 1); #1;
        tick(); clear_inputs(); #1;
        checks++; if (ctl !== 6'b011001) begin errors++; $display("FAIL mcbr_multi: ctl=%b expected=%b", ctl, 6'b011001); end
        tick();
        br_taken = 1; #1;
        $display("test_mcbr: branch in multi ctl=%b", ctl);
        checks++; if (ctl !== 6'b010111) begin errors++; $display("FAIL mcbr_br: ctl=%b expected=%b", ctl, 6'b010111); end
        tick(); clear_inputs(); #1;
        checks++; if (ctl !== 6'b010000 || busy_vec !== 8'h00) begin errors++; $display("FAIL mcbr_run: ctl=%b busy_vec=%h expected=%b/00", ctl, busy_vec, 6'b010000); end
        drive_write(4, 0, 1, 0); #1;
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL mcbr_reissue: ctl=%b expected=%b", ctl, 6'b100000); end
        tick();
        drive_write(5, 1, 0, 1); #1;
        tick(); clear_inputs(); #1;
        checks++; if (multi_busy !== 1'b1) begin errors++; $display("FAIL mcrst_multi: multi_busy=%b expected=1", multi_busy); end
        rst_n = 0; #1;
        $display("test_mcrst: reset in multi ctl=%b busy=%h", ctl, {busy_vec, busy_scl});
        checks++; if (ctl !== 6'b010000 || {busy_vec, busy_scl} !== 16'h0000) begin errors++; $display("FAIL mcrst_clear: ctl=%b busy=%h expected=%b/0000", ctl, {busy_vec, busy_scl}, 6'b010000); end
    endtask

    task automatic test_random(input int ncyc);
        int mc_left, r_rd;
        bit r_v, r_wv, r_ws, e_issue, e_bub, e_stall, e_fl, e_kl, haz;
        logic [5:0] e_ctl;
        logic [NREG-1:0] ev, es;
        do_reset();
        for (int r = 0; r < NREG; r++) begin m_vec[r] = 0; m_scl[r] = 0; end
        mc_left = 0; r_v = 0; r_rd = 0; r_wv = 0; r_ws = 0;
        for (int c = 0; c < ncyc; c++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = AW'($urandom_range(0, NREG - 1)); id_rs1_vec = 1'($urandom_range(0, 1)); id_rs1_use = 1'($urandom_range(0, 1));
            id_rs2 = AW'($urandom_range(0, NREG - 1)); id_rs2_vec = 1'($urandom_range(0, 1)); id_rs2_use = 1'($urandom_range(0, 1));
            id_rd = AW'($urandom_range(0, NREG - 1)); id_wrv = 1'($urandom_range(0, 1)); id_wrs = 1'($urandom_range(0, 1));
            id_multicycle = ($urandom_range(0, 7) == 0);
            wb_valid = 1'($urandom_range(0, 1)); wb_rd = AW'($urandom_range(0, NREG - 1));
            wb_wrv = 1'($urandom_range(0, 1)); wb_wrs = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 15) == 0);
            #1;
            haz = id_valid && ((id_rs1_use && pend(int'(id_rs1), id_rs1_vec)) || (id_rs2_use && pend(int'(id_rs2), id_rs2_vec))
                  || (id_wrv && pend(int'(id_rd), 1'b1)) || (id_wrs && pend(int'(id_rd), 1'b0)));
            if (br_taken) begin
                e_issue = 0; e_bub = 1; e_stall = 0; e_fl = 1; e_kl = 1;
            end else if (mc_left > 0) begin
                e_issue = 0; e_bub = 1; e_stall = 1; e_fl = 0; e_kl = 0;
            end else begin
                e_issue = id_valid && !haz; e_bub = !e_issue; e_stall = haz; e_fl = 0; e_kl = 0;
            end
            e_ctl = {e_issue, e_bub, e_stall, e_fl, e_kl, (mc_left > 0)};
            for (int r = 0; r < NREG; r++) begin ev[r] = m_vec[r]; es[r] = m_scl[r]; end
            $display("rand %0d: ctl=%b vec=%h scl=%h", c, ctl, busy_vec, busy_scl);
            checks++; if (ctl !== e_ctl) begin errors++; $display("FAIL rand_ctl cyc %0d: ctl=%b expected=%b", c, ctl, e_ctl); end
            checks++; if (busy_vec !== ev || busy_scl !== es) begin errors++; $display("FAIL rand_busy cyc %0d: vec=%h scl=%h expected=%h/%h", c, busy_vec, busy_scl, ev, es); end
            if (wb_valid && wb_wrv) m_vec[wb_rd] = 0;
            if (wb_valid && wb_wrs) m_scl[wb_rd] = 0;
            if (br_taken && r_v && r_wv) m_vec[r_rd] = 0;
            if (br_taken && r_v && r_ws) m_scl[r_rd] = 0;
            if (e_issue && id_wrv) m_vec[id_rd] = 1;
            if (e_issue && id_wrs) m_scl[id_rd] = 1;
            if (br_taken) r_v = 0;
            else if (mc_left > 0) r_v = r_v;
            else if (e_issue) begin r_v = 1; r_rd = int'(id_rd); r_wv = id_wrv; r_ws = id_wrs; end
            else r_v = 0;
            if (br_taken) mc_left = 0;
            else if (mc_left > 0) mc_left--;
            else if (e_issue && id_multicycle) mc_left = MC - 1;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_raw_wb_bypass();
        test_scalar_vs_vector();
        test_multicycle();
        test_branch_kill();
        test_set_wins();
        test_mc_branch_and_reset();
        test_random(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
